// File: rtl/itlb_4kb_maint_ctrl.sv
// ITLB 4KB array maintenance sequencer: shares the array's RMW port between walker fills and SFENCE.VMA flushes.
// Optional ITLB_MAINT_RESET_CLEAR_EN: run a silent flush-all sweep right after reset release.
module itlb_4kb_maint_ctrl #(
    parameter int WAYS       = 2,
    parameter int IW         = 4,
    parameter int ASID_WIDTH = 9,
    parameter int VPN_WIDTH  = 20,
    parameter int PPN_WIDTH  = 22
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [VPN_WIDTH-1:0]       fill_VPN,
    input  logic [ASID_WIDTH-1:0]      fill_ASID,
    input  logic                       fill_global,
    input  logic [PPN_WIDTH-1:0]       fill_PPN,
    input  logic                       sfence_valid,
    output logic                       sfence_ready,
    input  logic                       sfence_VPN_valid,
    input  logic                       sfence_ASID_valid,
    input  logic [VPN_WIDTH-1:0]       sfence_VPN,
    input  logic [ASID_WIDTH-1:0]      sfence_ASID,
    output logic                       flush_active,
    output logic                       flush_done,
    output logic                       arr_rd_valid,
    output logic [IW-1:0]              arr_rd_index,
    input  logic [WAYS-1:0]            arr_rd_valid_by_way,
    input  logic [WAYS-1:0]            arr_rd_global_by_way,
    input  logic [WAYS*ASID_WIDTH-1:0] arr_rd_ASID_by_way,
    input  logic [WAYS*VPN_WIDTH-1:0]  arr_rd_VPN_by_way,
    output logic                       arr_wr_valid,
    output logic [IW-1:0]              arr_wr_index,
    output logic [WAYS-1:0]            arr_wr_way_mask,
    output logic                       arr_wr_inv,
    output logic [VPN_WIDTH-1:0]       arr_wr_VPN,
    output logic [ASID_WIDTH-1:0]      arr_wr_ASID,
    output logic                       arr_wr_global,
    output logic [PPN_WIDTH-1:0]       arr_wr_PPN
);
    localparam int RW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, FILL_RD, FILL_WR, FLUSH_RD, FLUSH_WR, FLUSH_ALL} state_t;

    state_t                state;
    logic [RW-1:0]         rr_ptr;
    logic [IW-1:0]         cnt;
    logic [VPN_WIDTH-1:0]  f_vpn, sf_vpn;
    logic [ASID_WIDTH-1:0] f_asid, sf_asid;
    logic [PPN_WIDTH-1:0]  f_ppn;
    logic                  f_global, sf_vpn_v, sf_asid_v;
    logic                  boot_go, silent, fill_acc, sf_acc, use_rr;
    logic [WAYS-1:0]       hit, free, fill_mask, flush_mask;

    function automatic logic [IW-1:0] vpn_hash(input logic [VPN_WIDTH-1:0] vpn);
        return vpn[IW-1:0] ^ vpn[2*IW-1:IW];
    endfunction

    function automatic logic [WAYS-1:0] lowest_set(input logic [WAYS-1:0] v);
        logic [WAYS-1:0] r;
        r = '0;
        for (int w = 0; w < WAYS; w++)
            if (v[w] && r == '0) r[w] = 1'b1;
        return r;
    endfunction

`ifdef ITLB_MAINT_RESET_CLEAR_EN
    logic boot;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            boot   <= 1'b1;
            silent <= 1'b0;
        end else if (boot) begin
            boot   <= 1'b0;
            silent <= 1'b1;
        end else if (state == FLUSH_ALL && cnt == '1) begin
            silent <= 1'b0;
        end
    end
    assign boot_go = boot;
`else
    assign boot_go = 1'b0;
    assign silent  = 1'b0;
`endif

    assign sfence_ready = (state == IDLE) && !boot_go;
    assign fill_ready   = sfence_ready && !sfence_valid;
    assign sf_acc       = sfence_valid && sfence_ready;
    assign fill_acc     = fill_valid && fill_ready;

    // Way selection and flush masks act on read data returned in the write cycle.
    always_comb begin
        hit        = '0;
        free       = '0;
        flush_mask = '0;
        for (int w = 0; w < WAYS; w++) begin
            logic vm, am, fm, v, g;
            v  = arr_rd_valid_by_way[w];
            g  = arr_rd_global_by_way[w];
            vm = arr_rd_VPN_by_way[w*VPN_WIDTH +: VPN_WIDTH] == sf_vpn;
            am = arr_rd_ASID_by_way[w*ASID_WIDTH +: ASID_WIDTH] == sf_asid;
            fm = arr_rd_VPN_by_way[w*VPN_WIDTH +: VPN_WIDTH] == f_vpn;
            hit[w]  = v && fm && (g || arr_rd_ASID_by_way[w*ASID_WIDTH +: ASID_WIDTH] == f_asid);
            free[w] = !v;
            if (sf_vpn_v && sf_asid_v) flush_mask[w] = v && vm && am && !g;
            else if (sf_vpn_v)         flush_mask[w] = v && vm;
            else                       flush_mask[w] = v && am && !g;
        end
        fill_mask = '0;
        use_rr    = 1'b0;
        if (|hit) begin
            fill_mask = lowest_set(hit);
        end else if (|free) begin
            fill_mask = lowest_set(free);
        end else begin
            fill_mask[rr_ptr] = 1'b1;
            use_rr = 1'b1;
        end
    end

    always_comb begin
        arr_rd_valid    = 1'b0;
        arr_rd_index    = '0;
        arr_wr_valid    = 1'b0;
        arr_wr_index    = '0;
        arr_wr_way_mask = '0;
        arr_wr_inv      = 1'b0;
        arr_wr_VPN      = '0;
        arr_wr_ASID     = '0;
        arr_wr_global   = 1'b0;
        arr_wr_PPN      = '0;
        flush_active    = (state == FLUSH_RD) || (state == FLUSH_WR) || (state == FLUSH_ALL);
        case (state)
            FILL_RD: begin
                arr_rd_valid = 1'b1;
                arr_rd_index = vpn_hash(f_vpn);
            end
            FILL_WR: begin
                arr_wr_valid    = 1'b1;
                arr_wr_index    = vpn_hash(f_vpn);
                arr_wr_way_mask = fill_mask;
                arr_wr_VPN      = f_vpn;
                arr_wr_ASID     = f_asid;
                arr_wr_global   = f_global;
                arr_wr_PPN      = f_ppn;
            end
            FLUSH_RD: begin
                arr_rd_valid = 1'b1;
                arr_rd_index = cnt;
            end
            FLUSH_WR: begin
                arr_wr_valid    = |flush_mask;
                arr_wr_index    = arr_wr_valid ? cnt : '0;
                arr_wr_way_mask = flush_mask;
                arr_wr_inv      = arr_wr_valid;
            end
            FLUSH_ALL: begin
                arr_wr_valid    = 1'b1;
                arr_wr_index    = cnt;
                arr_wr_way_mask = '1;
                arr_wr_inv      = 1'b1;
            end
            default: ;
        endcase
    end

    // Request fields are data only; they are consumed solely in the states they lead to.
    always_ff @(posedge CLK) begin
        if (fill_acc) begin
            f_vpn    <= fill_VPN;
            f_asid   <= fill_ASID;
            f_global <= fill_global;
            f_ppn    <= fill_PPN;
        end
        if (sf_acc) begin
            sf_vpn    <= sfence_VPN;
            sf_asid   <= sfence_ASID;
            sf_vpn_v  <= sfence_VPN_valid;
            sf_asid_v <= sfence_ASID_valid;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot_go) begin
                        state <= FLUSH_ALL;
                        cnt   <= '0;
                    end else if (sf_acc) begin
                        if (!sfence_VPN_valid && !sfence_ASID_valid) begin
                            state <= FLUSH_ALL;
                            cnt   <= '0;
                        end else begin
                            state <= FLUSH_RD;
                            cnt   <= sfence_VPN_valid ? vpn_hash(sfence_VPN) : '0;
                        end
                    end else if (fill_acc) begin
                        state <= FILL_RD;
                    end
                end
                FILL_RD: state <= FILL_WR;
                FILL_WR: begin
                    if (use_rr) rr_ptr <= (rr_ptr == RW'(WAYS - 1)) ? '0 : rr_ptr + 1'b1;
                    state <= IDLE;
                end
                FLUSH_RD: state <= FLUSH_WR;
                FLUSH_WR: begin
                    if (sf_vpn_v || cnt == '1) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= FLUSH_RD;
                    end
                end
                FLUSH_ALL: begin
                    if (cnt == '1) begin
                        state      <= IDLE;
                        flush_done <= !silent;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_itlb_4kb_maint_ctrl.sv
// Directed bench for itlb_4kb_maint_ctrl with a small behavioural array read-port stub.
module tb_itlb_4kb_maint_ctrl;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        fill_valid, fill_ready, fill_global;
    logic [19:0] fill_VPN;
    logic [8:0]  fill_ASID;
    logic [21:0] fill_PPN;
    logic        sfence_valid, sfence_ready, sfence_VPN_valid, sfence_ASID_valid;
    logic [19:0] sfence_VPN;
    logic [8:0]  sfence_ASID;
    logic        flush_active, flush_done;
    logic        arr_rd_valid;
    logic [3:0]  arr_rd_index;
    logic [1:0]  rd_v, rd_g;
    logic [17:0] rd_asid;
    logic [39:0] rd_vpn;
    logic        arr_wr_valid, arr_wr_inv, arr_wr_global;
    logic [3:0]  arr_wr_index;
    logic [1:0]  arr_wr_way_mask;
    logic [19:0] arr_wr_VPN;
    logic [8:0]  arr_wr_ASID;
    logic [21:0] arr_wr_PPN;

    logic [1:0]  m_v[16], m_g[16];
    logic [17:0] m_asid[16];
    logic [39:0] m_vpn[16];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    itlb_4kb_maint_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_VPN(fill_VPN),
        .fill_ASID(fill_ASID), .fill_global(fill_global), .fill_PPN(fill_PPN),
        .sfence_valid(sfence_valid), .sfence_ready(sfence_ready),
        .sfence_VPN_valid(sfence_VPN_valid), .sfence_ASID_valid(sfence_ASID_valid),
        .sfence_VPN(sfence_VPN), .sfence_ASID(sfence_ASID),
        .flush_active(flush_active), .flush_done(flush_done),
        .arr_rd_valid(arr_rd_valid), .arr_rd_index(arr_rd_index),
        .arr_rd_valid_by_way(rd_v), .arr_rd_global_by_way(rd_g),
        .arr_rd_ASID_by_way(rd_asid), .arr_rd_VPN_by_way(rd_vpn),
        .arr_wr_valid(arr_wr_valid), .arr_wr_index(arr_wr_index),
        .arr_wr_way_mask(arr_wr_way_mask), .arr_wr_inv(arr_wr_inv),
        .arr_wr_VPN(arr_wr_VPN), .arr_wr_ASID(arr_wr_ASID),
        .arr_wr_global(arr_wr_global), .arr_wr_PPN(arr_wr_PPN)
    );

    // Array read port: data appears the cycle after the strobe.
    always @(posedge CLK) begin
        if (arr_rd_valid) begin
            rd_v    <= m_v[arr_rd_index];
            rd_g    <= m_g[arr_rd_index];
            rd_asid <= m_asid[arr_rd_index];
            rd_vpn  <= m_vpn[arr_rd_index];
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mem();
        for (int s = 0; s < 16; s++) begin
            m_v[s] = '0; m_g[s] = '0; m_asid[s] = '0; m_vpn[s] = '0;
        end
    endtask

    task automatic set_way(input int s, input int w, input logic v, input logic g,
                           input logic [8:0] asid, input logic [19:0] vpn);
        m_v[s][w] = v;
        m_g[s][w] = g;
        m_asid[s][w*9 +: 9]   = asid;
        m_vpn[s][w*20 +: 20]  = vpn;
    endtask

    // Returns in cycle T+1 of an accepted fill.
    task automatic start_fill(input logic [19:0] vpn, input logic [8:0] asid,
                              input logic g, input logic [21:0] ppn);
        fill_VPN = vpn; fill_ASID = asid; fill_global = g; fill_PPN = ppn;
        fill_valid = 1'b1;
        step();
        fill_valid = 1'b0;
        #1;
    endtask

    task automatic start_sfence(input logic vv, input logic av,
                                input logic [19:0] vpn, input logic [8:0] asid);
        sfence_VPN_valid = vv; sfence_ASID_valid = av;
        sfence_VPN = vpn; sfence_ASID = asid;
        sfence_valid = 1'b1;
        step();
        sfence_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        total++; if (fill_ready !== 1'b1) begin bad++; $display("FAIL rst_fill_ready got=%b exp=1", fill_ready); end
        total++; if (sfence_ready !== 1'b1) begin bad++; $display("FAIL rst_sfence_ready got=%b exp=1", sfence_ready); end
        total++; if (arr_wr_valid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got=%b exp=0", arr_wr_valid); end
        total++; if (arr_rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", arr_rd_valid); end
        total++; if ({flush_active, flush_done} !== 2'b00) begin bad++; $display("FAIL rst_flush got=%b exp=00", {flush_active, flush_done}); end
        total++; if (arr_wr_way_mask !== 2'b00) begin bad++; $display("FAIL rst_mask got=%b exp=00", arr_wr_way_mask); end
    endtask

    task automatic test_fill_basic();
        clear_mem();
        total++; if (fill_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_idle got=%b exp=1", fill_ready); end
        start_fill(20'h00123, 9'd5, 1'b0, 22'h2abcde);
        total++; if ({arr_rd_valid, arr_rd_index} !== {1'b1, 4'h1}) begin bad++; $display("FAIL fill_rd got=%b/%h exp=1/1", arr_rd_valid, arr_rd_index); end
        total++; if (fill_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_busy got=%b exp=0", fill_ready); end
        step();
        total++; if ({arr_wr_valid, arr_wr_index, arr_wr_way_mask, arr_wr_inv} !== {1'b1, 4'h1, 2'b01, 1'b0}) begin
            bad++; $display("FAIL fill_wr got=%b/%h/%b/%b exp=1/1/01/0", arr_wr_valid, arr_wr_index, arr_wr_way_mask, arr_wr_inv); end
        total++; if ({arr_wr_VPN, arr_wr_ASID, arr_wr_global, arr_wr_PPN} !== {20'h00123, 9'd5, 1'b0, 22'h2abcde}) begin
            bad++; $display("FAIL fill_data got=%h/%h/%b/%h exp=00123/005/0/2abcde", arr_wr_VPN, arr_wr_ASID, arr_wr_global, arr_wr_PPN); end
        total++; if (flush_active !== 1'b0) begin bad++; $display("FAIL fill_no_flush got=%b exp=0", flush_active); end
        step();
        total++; if ({arr_wr_valid, fill_ready} !== 2'b01) begin bad++; $display("FAIL fill_end got=%b exp=01", {arr_wr_valid, fill_ready}); end
    endtask

    task automatic test_fill_rr();
        clear_mem();
        set_way(1, 0, 1'b1, 1'b0, 9'd5, 20'h00456);
        set_way(1, 1, 1'b1, 1'b0, 9'd5, 20'h00789);
        start_fill(20'h00123, 9'd5, 1'b0, 22'h1);
        step();
        total++; if (arr_wr_way_mask !== 2'b01) begin bad++; $display("FAIL rr_first got=%b exp=01", arr_wr_way_mask); end
        step();
        start_fill(20'h00123, 9'd5, 1'b0, 22'h2);
        step();
        total++; if (arr_wr_way_mask !== 2'b10) begin bad++; $display("FAIL rr_second got=%b exp=10", arr_wr_way_mask); end
        step();
    endtask

    task automatic test_fill_choice();
        // rr_ptr is back at 0 here; a global hit in way1 must win and leave rr_ptr alone
        clear_mem();
        set_way(1, 0, 1'b1, 1'b0, 9'd5, 20'h00456);
        set_way(1, 1, 1'b1, 1'b1, 9'd9, 20'h00123);
        start_fill(20'h00123, 9'd5, 1'b0, 22'h3);
        step();
        total++; if (arr_wr_way_mask !== 2'b10) begin bad++; $display("FAIL global_hit got=%b exp=10", arr_wr_way_mask); end
        step();
        set_way(1, 1, 1'b1, 1'b0, 9'd9, 20'h00123);
        start_fill(20'h00123, 9'd5, 1'b0, 22'h4);
        step();
        total++; if (arr_wr_way_mask !== 2'b01) begin bad++; $display("FAIL asid_miss_rr got=%b exp=01", arr_wr_way_mask); end
        step();
        set_way(1, 0, 1'b0, 1'b0, 9'd5, 20'h00456);
        start_fill(20'h00123, 9'd5, 1'b0, 22'h5);
        step();
        total++; if (arr_wr_way_mask !== 2'b01) begin bad++; $display("FAIL lowest_invalid got=%b exp=01", arr_wr_way_mask); end
        step();
    endtask

    task automatic test_flush_all();
        int errs = 0;
        start_sfence(1'b0, 1'b0, 20'h0, 9'h0);
        for (int k = 0; k < 16; k++) begin
            if ({arr_wr_valid, arr_wr_index, arr_wr_way_mask, arr_wr_inv, flush_active, arr_rd_valid, flush_done}
                !== {1'b1, 4'(k), 2'b11, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errs++;
                $display("FAIL flush_all_k%0d got=%b/%h/%b/%b/%b exp=1/%h/11/1/1", k, arr_wr_valid, arr_wr_index, arr_wr_way_mask, arr_wr_inv, flush_active, 4'(k));
            end
            step();
        end
        total++; if (errs != 0) bad++;
        total++; if ({flush_done, flush_active, arr_wr_valid, sfence_ready} !== 4'b1001) begin
            bad++; $display("FAIL flush_all_done got=%b exp=1001", {flush_done, flush_active, arr_wr_valid, sfence_ready}); end
        step();
        total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL flush_all_pulse got=%b exp=0", flush_done); end
    endtask

    task automatic test_asid_sweep();
        int nwr = 0, fa_errs = 0;
        logic [3:0] widx = '0;
        logic [1:0] wmask = '0;
        clear_mem();
        set_way(1, 0, 1'b1, 1'b0, 9'd5, 20'h00123);
        set_way(1, 1, 1'b1, 1'b1, 9'd5, 20'h00456);
        set_way(7, 1, 1'b1, 1'b0, 9'd6, 20'h00777);
        start_sfence(1'b0, 1'b1, 20'h0, 9'd5);
        total++; if ({arr_rd_valid, arr_rd_index} !== {1'b1, 4'h0}) begin bad++; $display("FAIL sweep_first_rd got=%b/%h exp=1/0", arr_rd_valid, arr_rd_index); end
        for (int c = 1; c <= 32; c++) begin
            if (flush_active !== 1'b1 || flush_done !== 1'b0) fa_errs++;
            if (arr_wr_valid === 1'b1) begin
                nwr++; widx = arr_wr_index; wmask = arr_wr_way_mask;
            end
            step();
        end
        total++; if (fa_errs != 0) begin bad++; $display("FAIL sweep_active got=%0d exp=0 bad cycles", fa_errs); end
        total++; if (nwr != 1) begin bad++; $display("FAIL sweep_writes got=%0d exp=1", nwr); end
        total++; if ({widx, wmask} !== {4'h1, 2'b01}) begin bad++; $display("FAIL sweep_write got=%h/%b exp=1/01", widx, wmask); end
        total++; if ({flush_done, flush_active} !== 2'b10) begin bad++; $display("FAIL sweep_done got=%b exp=10", {flush_done, flush_active}); end
        step();
    endtask

    task automatic test_single_flush();
        clear_mem();
        set_way(1, 0, 1'b1, 1'b0, 9'd5, 20'h00123);
        start_sfence(1'b1, 1'b1, 20'h00123, 9'd7);
        total++; if ({arr_rd_valid, arr_rd_index, flush_active} !== {1'b1, 4'h1, 1'b1}) begin
            bad++; $display("FAIL single_rd got=%b/%h/%b exp=1/1/1", arr_rd_valid, arr_rd_index, flush_active); end
        step();
        total++; if ({arr_wr_valid, flush_active} !== 2'b01) begin bad++; $display("FAIL single_nowr got=%b exp=01", {arr_wr_valid, flush_active}); end
        step();
        total++; if ({flush_done, flush_active} !== 2'b10) begin bad++; $display("FAIL single_done got=%b exp=10", {flush_done, flush_active}); end
        step();
        // VPN-only removes global entries too
        set_way(1, 1, 1'b1, 1'b1, 9'd9, 20'h00123);
        start_sfence(1'b1, 1'b0, 20'h00123, 9'd0);
        step();
        total++; if ({arr_wr_valid, arr_wr_index, arr_wr_way_mask, arr_wr_inv} !== {1'b1, 4'h1, 2'b11, 1'b1}) begin
            bad++; $display("FAIL vpn_only got=%b/%h/%b/%b exp=1/1/11/1", arr_wr_valid, arr_wr_index, arr_wr_way_mask, arr_wr_inv); end
        step();
        total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL vpn_only_done got=%b exp=1", flush_done); end
        step();
        start_sfence(1'b1, 1'b1, 20'h00123, 9'd5);
        step();
        total++; if ({arr_wr_valid, arr_wr_way_mask} !== {1'b1, 2'b01}) begin
            bad++; $display("FAIL vpn_asid got=%b/%b exp=1/01", arr_wr_valid, arr_wr_way_mask); end
        step();
        step();
    endtask

    task automatic test_priority();
        clear_mem();
        fill_VPN = 20'h000AB; fill_ASID = 9'd3; fill_global = 1'b0; fill_PPN = 22'h7;
        fill_valid = 1'b1;
        sfence_VPN_valid = 1'b1; sfence_ASID_valid = 1'b0; sfence_VPN = 20'h00123; sfence_ASID = '0;
        sfence_valid = 1'b1;
        #1;
        total++; if ({fill_ready, sfence_ready} !== 2'b01) begin bad++; $display("FAIL prio_ready got=%b exp=01", {fill_ready, sfence_ready}); end
        step();
        sfence_valid = 1'b0;
        #1;
        total++; if ({fill_ready, flush_active, arr_rd_index} !== {1'b0, 1'b1, 4'h1}) begin
            bad++; $display("FAIL prio_t1 got=%b/%b/%h exp=0/1/1", fill_ready, flush_active, arr_rd_index); end
        step();
        total++; if (fill_ready !== 1'b0) begin bad++; $display("FAIL prio_t2 got=%b exp=0", fill_ready); end
        step();
        total++; if ({flush_done, fill_ready} !== 2'b11) begin bad++; $display("FAIL prio_t3 got=%b exp=11", {flush_done, fill_ready}); end
        step();
        fill_valid = 1'b0;
        #1;
        total++; if ({arr_rd_valid, arr_rd_index} !== {1'b1, 4'h1}) begin bad++; $display("FAIL prio_fill_rd got=%b/%h exp=1/1", arr_rd_valid, arr_rd_index); end
        step();
        total++; if ({arr_wr_valid, arr_wr_inv, arr_wr_way_mask} !== {1'b1, 1'b0, 2'b01}) begin
            bad++; $display("FAIL prio_fill_wr got=%b/%b/%b exp=1/0/01", arr_wr_valid, arr_wr_inv, arr_wr_way_mask); end
        step();
    endtask

    task automatic test_reset_mid();
        start_sfence(1'b0, 1'b0, 20'h0, 9'h0);
        step(); step(); step();
        #3;
        nRST = 1'b0;
        #1;
        total++; if ({arr_wr_valid, flush_active, arr_wr_way_mask} !== 4'b0000) begin
            bad++; $display("FAIL midrst_out got=%b/%b/%b exp=0/0/00", arr_wr_valid, flush_active, arr_wr_way_mask); end
        total++; if ({fill_ready, sfence_ready} !== 2'b11) begin bad++; $display("FAIL midrst_ready got=%b exp=11", {fill_ready, sfence_ready}); end
        step();
        nRST = 1'b1;
        step(); step();
        total++; if ({flush_active, flush_done, arr_wr_valid} !== 3'b000) begin
            bad++; $display("FAIL midrst_after got=%b exp=000", {flush_active, flush_done, arr_wr_valid}); end
    endtask

    initial begin
        nRST = 1'b0;
        fill_valid = 1'b0; fill_VPN = '0; fill_ASID = '0; fill_global = 1'b0; fill_PPN = '0;
        sfence_valid = 1'b0; sfence_VPN_valid = 1'b0; sfence_ASID_valid = 1'b0;
        sfence_VPN = '0; sfence_ASID = '0;
        rd_v = '0; rd_g = '0; rd_asid = '0; rd_vpn = '0;
        clear_mem();
        #2;
        test_reset();
        step();
        nRST = 1'b1;
        step();
        test_fill_basic();
        test_fill_rr();
        test_fill_choice();
        test_flush_all();
        test_asid_sweep();
        test_single_flush();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
